goertzel_mb: RTL
================

Name: goertzel_mb

Overview:
- Multi-bin, fixed-point, single-clock successor to the floating-point single-tone Goertzel detector.
- One time-multiplexed multiply-accumulate (MAC) datapath runs N_BINS independent Goertzel recurrences over blocks of BLOCK_LEN samples.
- Per-bin 2cos(w) coefficients are run-time loadable.
- Sits between the ADC sample strobe (sample_valid at about 1.3 MHz on the 130 MHz clock) and the tone-decision logic, which consumes per-bin power over a valid/ready stream.

Parameters:
- SAMPLE_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width; format Q2.(COEF_W-2), so range is [-2.0, 2.0).
- ACC_W, 40, signed q1/q2 state width; wraps on overflow, two's complement.
- N_BINS, 8, number of frequency bins (1..32).
- BLOCK_LEN, 5200, samples per Goertzel block (>=2).
- POW_W, 32, output power width (unsigned).
- PSHIFT, 32, right shift applied to full-precision power before saturation.

Ports:
- clock  in  1  system clock, 130 MHz.
- reset_n  in  1  reset: synchronous, active-low.
- sample  in  SAMPLE_W  signed input sample.
- sample_valid  in  1  sample strobe.
- sample_ready  out  1  high when a sample can be accepted.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  $clog2(N_BINS)  bin index for the write.
- coef_data  in  COEF_W  coefficient value, 2cos(2*pi*k/BLOCK_LEN).
- out_valid  out  1  power result valid.
- out_ready  in  1  consumer accepts the result.
- out_bin  out  $clog2(N_BINS)  bin index of out_power.
- out_power  out  POW_W  bin power.
- out_last  out  1  marks the bin N_BINS-1 result.
- overrun  out  1  sticky: a sample arrived while sample_ready was low.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (reset_n low at a clock edge):
  - All q1/q2 states, coefficients, the sample counter and overrun go to 0.
  - FSM goes to IDLE.
  - sample_ready=1, out_valid=0, out_bin=0, out_power=0, out_last=0.
  - Reset mid-operation aborts the block; no partial result is emitted.
- FSM states: IDLE, ITER, PWR, OUT, CLR.
- IDLE:
  - sample_ready=1.
  - sample_valid&sample_ready at cycle t latches the sample and moves to ITER.
- ITER:
  - Bins 0..N_BINS-1 are issued one per cycle through a 2-stage pipeline (multiply, then add/writeback).
  - Recurrence: q0 = sample + ((coef*q1) >>> (COEF_W-2)) - q2, then q2<=q1, q1<=q0.
  - Arithmetic: full-precision product, arithmetic shift, truncate to ACC_W.
  - sample_ready is low from t+1 through t+N_BINS+2. The counter increments at t+N_BINS+2.
  - If the counter < BLOCK_LEN, return to IDLE; sample_ready=1 at t+N_BINS+3.
  - If the counter = BLOCK_LEN, go to PWR.
- PWR (bin b, starting at b=0):
  - P = q1^2 + q2^2 - ((coef*q1*q2) >>> (COEF_W-2)), computed signed at full precision.
  - Then P >>> PSHIFT. Negative values clamp to 0; values >= 2^POW_W saturate to 2^POW_W-1.
  - 3-cycle pipeline, then go to OUT.
- OUT:
  - out_valid=1 with out_bin=b and out_power held stable until out_ready.
  - out_last = (b==N_BINS-1).
  - On handshake: if b<N_BINS-1, out_valid drops the next cycle and PWR runs for b+1; otherwise go to CLR.
  - out_ready while out_valid=0 is ignored.
- CLR: one cycle that zeroes every q1/q2 and the counter, then goes to IDLE.
- sample_ready is low in ITER/PWR/OUT/CLR.
  - sample_valid while sample_ready is low: the sample is dropped and overrun<=1.
  - If overrun_clr and a drop occur in the same cycle, the set wins.
- Coefficients:
  - coef_we is honoured only in IDLE with the counter = 0 (block boundary); otherwise it is ignored.
  - Writes to coef_addr >= N_BINS are ignored.
  - A write takes effect on the next accepted sample.
- Throughput: requires N_BINS+3 <= clock cycles per sample period; the default config has 100 cycles/sample.

Decomposition:
- Package goertzel_pkg holds:
  - the FSM state enum;
  - the localparam FRAC = COEF_W-2;
  - a saturating-truncate function for the power result;
  - the BIN_W = $clog2(N_BINS) helper.
- One sub-module, goertzel_mac: the shared 2-stage pipelined signed multiply/shift/add unit, reused by ITER and PWR through an operand mux.

Test Plan:
- Reset check: hold reset_n=0 for 4 cycles -> sample_ready=1, out_valid=0, overrun=0, out_power=0, all coefficients read back as 0 via zero power output.
- fs/4 tone: BLOCK_LEN=4, PSHIFT=0, coef[0]=0x0000; samples 1000,0,-1000,0 -> bin0 out_power=4000000.
- fs/2 tone: coef[1]=0x8000 (-2.0); samples 100,-100,100,-100 -> bin1 out_power=160000.
- DC rejection: coef[0]=0; samples 100 x4 -> bin0 out_power=0.
  - Results arrive as bins 0..N_BINS-1 in order, with out_last only on the last bin.
- Backpressure and protocol:
  - Hold out_ready=0 for 50 cycles -> out_valid, out_bin and out_power remain stable.
  - Pulse sample_valid during OUT -> sample dropped, overrun=1.
  - overrun_clr -> overrun=0.
- Boundary and reset:
  - coef_we mid-block -> ignored; result unchanged.
  - Assert reset_n=0 during ITER of sample 3 -> no out_valid occurs.
  - The next full block gives the same power values as a clean run.

Source files
------------

// File: rtl/goertzel_pkg.sv
// rtl/goertzel_pkg.sv - shared states and helpers for the multi-bin Goertzel detector
package goertzel_pkg;

    // Controller states
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ITER = 3'd1;
    localparam logic [2:0] ST_PWR  = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_CLR  = 3'd4;

    // Coefficients are Q2.(COEF_W-2): fraction bits of a coefficient word
    function automatic int frac_bits(input int coef_w);
        return coef_w - 2;
    endfunction

    // Bin index width, never narrower than one bit so a single-bin build still has a port
    function automatic int bin_w(input int n_bins);
        return (n_bins > 1) ? $clog2(n_bins) : 1;
    endfunction

    // Clamp a shifted power value into pow_w unsigned bits (negative -> 0, too large -> all ones)
    function automatic logic [63:0] sat_pow(input logic signed [127:0] p, input int pow_w);
        logic signed [127:0] lim;
        lim = 128'sd1 <<< pow_w;
        if (p < 0) begin
            return '0;
        end
        if (p >= lim) begin
            return (64'd1 << pow_w) - 64'd1;
        end
        return p[63:0];
    endfunction

endpackage

// File: rtl/goertzel_mac.sv
// rtl/goertzel_mac.sv - shared two-stage signed multiply / shift / add unit
module goertzel_mac
    import goertzel_pkg::*;
#(
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int PW     = 98
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [ACC_W-1:0]  x,
    input  logic signed [ACC_W-1:0]  y,
    input  logic signed [PW-1:0]     add,
    input  logic                     sub,
    output logic signed [PW-1:0]     result
);

    localparam int P1W  = COEF_W + ACC_W;
    localparam int FRAC = frac_bits(COEF_W);

    logic signed [P1W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0] y_q, y_d;
    logic signed [PW-1:0] add_q, add_d;
    logic sub_q, sub_d;

    logic signed [P1W-1:0] coef_w, x_w;
    logic signed [PW-1:0] prod_w, y_w, term;

    // Stage 1: full-precision coef*x, carry the second factor and addend alongside
    always_comb begin
        coef_w = coef;
        x_w    = x;
        prod_d = coef_w * x_w;
        y_d    = y;
        add_d  = add;
        sub_d  = sub;
    end

    // Stage 1 pipeline register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prod_q <= '0;
            y_q    <= '0;
            add_q  <= '0;
            sub_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            y_q    <= y_d;
            add_q  <= add_d;
            sub_q  <= sub_d;
        end
    end

    // Stage 2: second multiply, drop the coefficient fraction bits, then add or subtract
    always_comb begin
        prod_w = prod_q;
        y_w    = y_q;
        term   = (prod_w * y_w) >>> FRAC;
        result = sub_q ? (add_q - term) : (add_q + term);
    end

endmodule

// File: rtl/goertzel_mb.sv
// rtl/goertzel_mb.sv - multi-bin fixed-point Goertzel detector with a shared MAC
module goertzel_mb
    import goertzel_pkg::*;
#(
    parameter int SAMPLE_W  = 16,
    parameter int COEF_W    = 16,
    parameter int ACC_W     = 40,
    parameter int N_BINS    = 8,
    parameter int BLOCK_LEN = 5200,
    parameter int POW_W     = 32,
    parameter int PSHIFT    = 32
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [SAMPLE_W-1:0]         sample,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic                        coef_we,
    input  logic [bin_w(N_BINS)-1:0]    coef_addr,
    input  logic [COEF_W-1:0]           coef_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [bin_w(N_BINS)-1:0]    out_bin,
    output logic [POW_W-1:0]            out_power,
    output logic                        out_last,
    output logic                        overrun,
    input  logic                        overrun_clr
);

    localparam int BIN_W  = bin_w(N_BINS);
    localparam int STEP_W = $clog2(N_BINS + 2) + 1;
    localparam int CNT_W  = $clog2(BLOCK_LEN + 1);
    localparam int PW     = 2 * ACC_W + COEF_W + 2;

    logic [2:0] state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic signed [COEF_W-1:0] coef_q [N_BINS];
    logic signed [COEF_W-1:0] coef_d [N_BINS];
    logic signed [ACC_W-1:0] q1_q [N_BINS];
    logic signed [ACC_W-1:0] q1_d [N_BINS];
    logic signed [ACC_W-1:0] q2_q [N_BINS];
    logic signed [ACC_W-1:0] q2_d [N_BINS];
    logic signed [PW-1:0] pwr_q, pwr_d;
    logic [POW_W-1:0] out_power_q, out_power_d;
    logic overrun_q, overrun_d;

    logic [BIN_W-1:0] rd_idx, wb_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic signed [COEF_W-1:0] coef_rd;
    logic signed [ACC_W-1:0] q1_rd, q2_rd, mac_y;
    logic signed [PW-1:0] samp_w, q1_w, q2_w, mac_add, mac_result;
    logic mac_sub, drop;

    // Operand mux: ITER walks bins by step, PWR works on the bin currently being reported
    always_comb begin
        rd_idx  = (state_q == ST_ITER) ? BIN_W'(step_q) : bin_q;
        wb_idx  = BIN_W'(step_q - STEP_W'(1));
        coef_rd = coef_q[rd_idx];
        q1_rd   = q1_q[rd_idx];
        q2_rd   = q2_q[rd_idx];
        samp_w  = sample_q;
        q1_w    = q1_rd;
        q2_w    = q2_rd;
        mac_sub = (state_q == ST_PWR);
        if (state_q == ST_PWR) begin
            mac_y   = q2_rd;
            mac_add = q1_w * q1_w + q2_w * q2_w;
        end else begin
            mac_y   = {{(ACC_W-1){1'b0}}, 1'b1};
            mac_add = samp_w - q2_w;
        end
    end

    goertzel_mac #(
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W),
        .PW     (PW)
    ) u_mac (
        .clock   (clock),
        .reset_n (reset_n),
        .coef    (coef_rd),
        .x       (q1_rd),
        .y       (mac_y),
        .add     (mac_add),
        .sub     (mac_sub),
        .result  (mac_result)
    );

    // Controller: sample intake, per-bin recurrence, power readout, end-of-block clear
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        coef_d      = coef_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        pwr_d       = pwr_q;
        out_power_d = out_power_q;
        cnt_inc     = cnt_q + CNT_W'(1);
        drop        = sample_valid && (state_q != ST_IDLE);
        overrun_d   = drop | (overrun_q & ~overrun_clr);

        case (state_q)
            ST_IDLE: begin
                if (coef_we && (cnt_q == '0) && (32'(coef_addr) < 32'(N_BINS))) begin
                    coef_d[coef_addr] = coef_data;
                end
                if (sample_valid) begin
                    sample_d = sample;
                    step_d   = '0;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                // Writeback lags issue by one cycle: step s retires bin s-1
                if ((step_q != '0) && (step_q <= STEP_W'(N_BINS))) begin
                    q2_d[wb_idx] = q1_q[wb_idx];
                    q1_d[wb_idx] = mac_result[ACC_W-1:0];
                end
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(N_BINS + 1)) begin
                    step_d  = '0;
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CNT_W'(BLOCK_LEN)) ? ST_PWR : ST_IDLE;
                end
            end
            ST_PWR: begin
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(1)) begin
                    pwr_d = mac_result;
                end
                if (step_q == STEP_W'(2)) begin
                    out_power_d = POW_W'(sat_pow(128'(pwr_q >>> PSHIFT), POW_W));
                    step_d      = '0;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (bin_q == BIN_W'(N_BINS - 1)) begin
                        state_d = ST_CLR;
                    end else begin
                        bin_d   = bin_q + BIN_W'(1);
                        state_d = ST_PWR;
                    end
                end
            end
            ST_CLR: begin
                q1_d    = '{default: '0};
                q2_d    = '{default: '0};
                cnt_d   = '0;
                bin_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any block in progress
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            coef_q      <= '{default: '0};
            q1_q        <= '{default: '0};
            q2_q        <= '{default: '0};
            pwr_q       <= '0;
            out_power_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            coef_q      <= coef_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            pwr_q       <= pwr_d;
            out_power_q <= out_power_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_ready = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_OUT);
    assign out_bin      = bin_q;
    assign out_power    = out_power_q;
    assign out_last     = out_valid && (bin_q == BIN_W'(N_BINS - 1));
    assign overrun      = overrun_q;

endmodule
